ppu_tile_sequencer: RTL and testbench
=====================================

// Module: ppu_tile_sequencer
// PURPOSE
//  Sequences the post-processing unit (scale/bias/ReLU/quantize PPU) over a run of output tiles.
//  Per tile: streams ROWS partial-sum rows from the accumulator buffer into the PPU, then waits for ppu_done.
//  It then writes the 136-bit quantized row (16x8b data + 8b scale) to the output buffer.
//  Sits between the top-level command decoder and the ppu/accumulator/output-buffer datapath.
// PARAMETERS
//  ROWS     16    partial-sum rows streamed per tile
//  PSUM_W   384   accumulator row width (16 x 24b)
//  OUT_W    136   PPU output width
//  ADDR_W   8     accumulator / output buffer address width
//  TILE_W   6     tile-count width (1..2^TILE_W-1 tiles per run)
//  TIMEOUT  1023  max cycles waiting for ppu_done (used only with PPU_TIMEOUT_EN)
// PORTS
//  clk           in   1       clock
//  rst_n         in   1       async active-low reset
//  start         in   1       1-cycle run request; ignored unless idle
//  num_tiles     in   TILE_W  tiles in run, sampled at start; 0 => run completes immediately
//  base_addr     in   ADDR_W  first accumulator row address, sampled at start
//  cfg_scale     in   8       sampled at start, held on ppu_scale for whole run
//  cfg_bias      in   8       sampled at start, held on ppu_bias for whole run
//  acc_rd_en     out  1       accumulator read strobe
//  acc_rd_addr   out  ADDR_W  accumulator read address
//  acc_rd_data   in   PSUM_W  read data, valid 1 cycle after acc_rd_en
//  ppu_partial_sum out PSUM_W row to PPU (registered copy of acc_rd_data)
//  ppu_valid     out  1       row strobe to PPU
//  ppu_scale     out  8       scale to PPU
//  ppu_bias      out  8       bias to PPU
//  ppu_done      in   1       PPU result valid (level or pulse; first rising cycle counts)
//  ppu_data      in   OUT_W   PPU result
//  out_wr_en     out  1       output buffer write strobe
//  out_wr_addr   out  ADDR_W  output row address (= tile index)
//  out_wr_data   out  OUT_W   registered ppu_data
//  busy          out  1       high from cycle after accepted start until cycle done pulses
//  run_done      out  1       1-cycle pulse at end of run
//  error         out  1       sticky timeout flag (PPU_TIMEOUT_EN only; else tied 0)
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, counters 0; error cleared only by rst_n or next accepted start.
//  FSM: IDLE -> FETCH on start (num_tiles!=0); IDLE -> FIN on start with num_tiles==0.
//   FETCH: ROWS consecutive cycles acc_rd_en=1, acc_rd_addr=base+tile*ROWS+row (mod 2^ADDR_W).
//   FETCH cont.: ppu_valid/ppu_partial_sum follow 1 cycle later, exactly ROWS back-to-back beats.
//   FETCH -> WAIT after last beat issued.
//   WAIT: ppu_valid=0; on ppu_done (first cycle high) capture ppu_data -> WRITE.
//   WRITE: out_wr_en=1 one cycle, addr=tile index; tile++ -> FETCH if tile<num_tiles, else FIN.
//   FIN: run_done=1 one cycle, busy=0 -> IDLE.
//  Latency per tile: ROWS+1 cycles fetch + PPU latency + 1 write cycle.
//  start while busy: ignored, no state change. start same cycle as FIN: ignored (accepted next cycle).
//  ppu_done during FETCH: ignored; WAIT only. ppu_done held high across WRITE: not re-captured.
//  Address wrap at 2^ADDR_W is silent modulo arithmetic.
//  Reset mid-run: immediate abort, all strobes low async, no partial write.
// CONFIGURATION
//  PPU_TIMEOUT_EN defined: WAIT counter; if ppu_done absent for TIMEOUT cycles -> error=1.
//   Timed-out tile still gets a write with out_wr_data=0; run continues with next tile.
//  PPU_TIMEOUT_EN undefined: WAIT waits forever; error tied 0; no counter logic.
// TESTING
//  T1 reset: rst_n low mid-FETCH -> acc_rd_en, ppu_valid, busy, out_wr_en all 0 same cycle.
//  T2 one tile: start, num_tiles=1, base=0x10, scale=3, bias=2.
//   T2 response: rd addr 0x10..0x1F, 16 ppu_valid beats, ppu_scale=3, ppu_bias=2.
//   T2 response cont.: ppu_done 5 cycles later -> out_wr_addr=0, data matches, run_done 1 cycle later.
//  T3 three tiles, base=0xF0: read addresses wrap 0xF0..0xFF,0x00..0x1F.
//   T3 response cont.: out_wr_addr 0,1,2; exactly 3 writes, 1 run_done.
//  T4 num_tiles=0 -> run_done 1 cycle after start, no reads/writes; start while busy -> ignored, counts unchanged.
//  T5 ppu_done pulsed during FETCH and held 4 cycles in WAIT -> exactly one write per tile.
//  T6 (PPU_TIMEOUT_EN, TIMEOUT=20) ppu_done never asserted -> error=1 after 20 WAIT cycles.
//   T6 response cont.: write of 0 issued; next start clears error.

Source files
------------

// File: rtl/ppu_tile_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : ppu_tile_sequencer_if
// Purpose  : Command, accumulator-read, PPU and output-write signals of the
//            PPU tile sequencer, bundled with sequencer/environment modports.
// Revision : 1.0  initial release
// ============================================================================
interface ppu_tile_sequencer_if #(
  parameter int PSUM_W = 384,
  parameter int OUT_W  = 136,
  parameter int ADDR_W = 8,
  parameter int TILE_W = 6
);
  // command side
  logic              start;
  logic [TILE_W-1:0] num_tiles;
  logic [ADDR_W-1:0] base_addr;
  logic [7:0]        cfg_scale;
  logic [7:0]        cfg_bias;
  // accumulator read port
  logic              acc_rd_en;
  logic [ADDR_W-1:0] acc_rd_addr;
  logic [PSUM_W-1:0] acc_rd_data;
  // PPU side
  logic [PSUM_W-1:0] ppu_partial_sum;
  logic              ppu_valid;
  logic [7:0]        ppu_scale;
  logic [7:0]        ppu_bias;
  logic              ppu_done;
  logic [OUT_W-1:0]  ppu_data;
  // output buffer write port
  logic              out_wr_en;
  logic [ADDR_W-1:0] out_wr_addr;
  logic [OUT_W-1:0]  out_wr_data;
  // status
  logic              busy;
  logic              run_done;
  logic              error;

  // sequencer view
  modport master (
    input  start, num_tiles, base_addr, cfg_scale, cfg_bias,
    input  acc_rd_data, ppu_done, ppu_data,
    output acc_rd_en, acc_rd_addr, ppu_partial_sum, ppu_valid,
    output ppu_scale, ppu_bias, out_wr_en, out_wr_addr, out_wr_data,
    output busy, run_done, error
  );

  // environment view (command decoder, accumulator, PPU, output buffer)
  modport slave (
    output start, num_tiles, base_addr, cfg_scale, cfg_bias,
    output acc_rd_data, ppu_done, ppu_data,
    input  acc_rd_en, acc_rd_addr, ppu_partial_sum, ppu_valid,
    input  ppu_scale, ppu_bias, out_wr_en, out_wr_addr, out_wr_data,
    input  busy, run_done, error
  );
endinterface
`default_nettype wire

// File: rtl/ppu_tile_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ppu_tile_sequencer
// Purpose  : Walks the PPU over a run of output tiles: streams ROWS partial-sum
//            rows per tile from the accumulator, waits for ppu_done, writes the
//            quantized row to the output buffer at the tile index.
// Options  : PPU_TIMEOUT_EN - bounded wait for ppu_done (TIMEOUT cycles); a
//            timed-out tile is written as zero and the sticky error is set.
// Revision : 1.0  initial release
// ============================================================================
module ppu_tile_sequencer #(
  parameter int ROWS    = 16,
  parameter int PSUM_W  = 384,
  parameter int OUT_W   = 136,
  parameter int ADDR_W  = 8,
  parameter int TILE_W  = 6,
  parameter int TIMEOUT = 1023
) (
  input wire clk,
  input wire rst_n,
  ppu_tile_sequencer_if.master bus
);

  localparam int c_ROW_W = $clog2(ROWS + 1);

  localparam logic [2:0] c_ST_IDLE  = 3'd0;
  localparam logic [2:0] c_ST_FETCH = 3'd1;
  localparam logic [2:0] c_ST_WAIT  = 3'd2;
  localparam logic [2:0] c_ST_WRITE = 3'd3;
  localparam logic [2:0] c_ST_FIN   = 3'd4;

  logic [2:0]         r_state;
  logic [c_ROW_W-1:0] r_row;        // 0..ROWS-1 issue reads, ROWS drains last beat
  logic [TILE_W-1:0]  r_tile;
  logic [TILE_W-1:0]  r_num_tiles;
  logic [ADDR_W-1:0]  r_base;
  logic [7:0]         r_scale;
  logic [7:0]         r_bias;
  logic               r_ppu_valid;
  logic [OUT_W-1:0]   r_out_data;

  logic               w_start_ok;
  logic               w_rd_en;
  logic               w_row_drain;
  logic               w_last_tile;
  logic               w_timeout;
  logic [ADDR_W-1:0]  w_tile_off;
  logic [ADDR_W-1:0]  w_rd_addr;

  assign w_start_ok  = (r_state == c_ST_IDLE) && bus.start;
  assign w_row_drain = (r_row == c_ROW_W'(ROWS));
  assign w_rd_en     = (r_state == c_ST_FETCH) && !w_row_drain;
  assign w_last_tile = (r_tile == r_num_tiles - TILE_W'(1));

  // Row address wraps silently at 2^ADDR_W.
  assign w_tile_off  = ADDR_W'(r_tile) * ADDR_W'(ROWS);
  assign w_rd_addr   = r_base + w_tile_off + ADDR_W'(r_row);

`ifdef PPU_TIMEOUT_EN
  localparam int c_TO_W = $clog2(TIMEOUT + 1);

  logic [c_TO_W-1:0] r_wait_cnt;
  logic              r_error;

  assign w_timeout = (r_state == c_ST_WAIT) && !bus.ppu_done &&
                     (r_wait_cnt == c_TO_W'(TIMEOUT - 1));

  // Count consecutive WAIT cycles; restarts on every entry to WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   r_wait_cnt <= '0;
    else if (r_state == c_ST_WAIT) r_wait_cnt <= r_wait_cnt + c_TO_W'(1);
    else                          r_wait_cnt <= '0;
  end

  // Sticky timeout flag, cleared only by reset or the next accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_error <= 1'b0;
    else if (w_start_ok) r_error <= 1'b0;
    else if (w_timeout)  r_error <= 1'b1;
  end

  assign bus.error = r_error;
`else
  assign w_timeout = 1'b0;
  assign bus.error = 1'b0;
`endif

  // Run/tile sequencing: sample the command, fetch rows, wait, write, finish.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= c_ST_IDLE;
      r_row       <= '0;
      r_tile      <= '0;
      r_num_tiles <= '0;
      r_base      <= '0;
      r_scale     <= '0;
      r_bias      <= '0;
      r_out_data  <= '0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (bus.start) begin
            r_num_tiles <= bus.num_tiles;
            r_base      <= bus.base_addr;
            r_scale     <= bus.cfg_scale;
            r_bias      <= bus.cfg_bias;
            r_tile      <= '0;
            r_row       <= '0;
            r_state     <= (bus.num_tiles == '0) ? c_ST_FIN : c_ST_FETCH;
          end
        end
        c_ST_FETCH: begin
          if (w_row_drain) begin
            r_row   <= '0;
            r_state <= c_ST_WAIT;
          end else begin
            r_row   <= r_row + c_ROW_W'(1);
          end
        end
        c_ST_WAIT: begin
          // Level-sensitive only here, so a done seen during FETCH is ignored
          // and one held through WRITE cannot be taken twice.
          if (bus.ppu_done) begin
            r_out_data <= bus.ppu_data;
            r_state    <= c_ST_WRITE;
          end else if (w_timeout) begin
            r_out_data <= '0;
            r_state    <= c_ST_WRITE;
          end
        end
        c_ST_WRITE: begin
          if (w_last_tile) begin
            r_state <= c_ST_FIN;
          end else begin
            r_tile  <= r_tile + TILE_W'(1);
            r_state <= c_ST_FETCH;
          end
        end
        c_ST_FIN: r_state <= c_ST_IDLE;
        default:  r_state <= c_ST_IDLE;
      endcase
    end
  end

  // PPU row strobe trails the accumulator read strobe by the read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ppu_valid <= 1'b0;
    else        r_ppu_valid <= w_rd_en;
  end

  assign bus.acc_rd_en       = w_rd_en;
  assign bus.acc_rd_addr     = w_rd_en ? w_rd_addr : '0;
  // The accumulator read port is registered, so acc_rd_data is already the
  // row register in the beat cycle; it is forwarded only while the beat is valid.
  assign bus.ppu_valid       = r_ppu_valid;
  assign bus.ppu_partial_sum = r_ppu_valid ? bus.acc_rd_data : '0;
  assign bus.ppu_scale       = r_scale;
  assign bus.ppu_bias        = r_bias;
  assign bus.out_wr_en       = (r_state == c_ST_WRITE);
  assign bus.out_wr_addr     = (r_state == c_ST_WRITE) ? ADDR_W'(r_tile) : '0;
  assign bus.out_wr_data     = r_out_data;
  assign bus.busy            = (r_state == c_ST_FETCH) || (r_state == c_ST_WAIT) ||
                               (r_state == c_ST_WRITE);
  assign bus.run_done        = (r_state == c_ST_FIN);

endmodule
`default_nettype wire

// File: tb/tb_ppu_tile_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ppu_tile_sequencer
// Purpose  : Randomized self-checking bench for ppu_tile_sequencer with an
//            accumulator memory model, a PPU responder and a run-level model.
// Revision : 1.0  initial release
// ============================================================================
module tb_ppu_tile_sequencer;
  localparam int ROWS   = 16;
  localparam int PSUM_W = 384;
  localparam int OUT_W  = 136;
  localparam int ADDR_W = 8;
  localparam int TILE_W = 6;
`ifdef PPU_TIMEOUT_EN
  localparam int TIMEOUT = 20;
`else
  localparam int TIMEOUT = 1023;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ppu_tile_sequencer_if #(.PSUM_W(PSUM_W), .OUT_W(OUT_W), .ADDR_W(ADDR_W), .TILE_W(TILE_W)) bus ();

  ppu_tile_sequencer #(
    .ROWS(ROWS), .PSUM_W(PSUM_W), .OUT_W(OUT_W), .ADDR_W(ADDR_W),
    .TILE_W(TILE_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [PSUM_W-1:0] obs, input logic [PSUM_W-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PSUM_W-1:0] rnd_wide();
    logic [PSUM_W-1:0] v;
    for (int i = 0; i < PSUM_W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // ---------------- environment models ----------------
  logic [PSUM_W-1:0] mem [256];
  logic [OUT_W-1:0]  tile_data [64];
  int cyc = 0;
  int start_ref = 0;
  int run_id = 0;
  int cfg_lat = 1, cfg_hold = 1;
  bit cfg_spur = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Accumulator: registered read, data one cycle after the strobe.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)             bus.acc_rd_data <= '0;
    else if (bus.acc_rd_en) bus.acc_rd_data <= mem[bus.acc_rd_addr];
  end

  // PPU: after ROWS beats, raise done cfg_lat cycles after the last beat and
  // hold it cfg_hold cycles; cfg_lat==0 means never answer.
  int  p_beats, p_wait, p_hold, p_tidx, p_id;
  bit  p_armed;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_beats = 0; p_wait = 0; p_hold = 0; p_tidx = 0; p_armed = 0; p_id = run_id;
      bus.ppu_done <= 1'b0;
      bus.ppu_data <= '0;
    end else begin
      if (p_id != run_id) begin
        p_beats = 0; p_tidx = 0; p_armed = 0; p_id = run_id;
      end
      if (p_hold > 0) begin
        p_hold--;
        if (p_hold == 0) bus.ppu_done <= 1'b0;
      end
      if (bus.ppu_valid) begin
        p_beats++;
        if (cfg_spur && p_beats == 5) begin
          bus.ppu_done <= 1'b1;
          bus.ppu_data <= '1;
          p_hold = 1;
        end
        if (p_beats == ROWS) begin
          p_beats = 0;
          p_armed = (cfg_lat > 0);
          p_wait  = cfg_lat;
        end
      end
      if (p_armed) begin
        p_wait--;
        if (p_wait == 0) begin
          p_armed = 0;
          bus.ppu_done <= 1'b1;
          bus.ppu_data <= tile_data[p_tidx];
          p_tidx++;
          p_hold = cfg_hold;
        end
      end
    end
  end

  // Monitor: collect what the DUT did during the current run.
  logic [ADDR_W-1:0] q_rd[$];
  logic [PSUM_W-1:0] q_beat[$];
  logic [15:0]       q_sb[$];
  logic [ADDR_W-1:0] q_wa[$];
  logic [OUT_W-1:0]  q_wd[$];
  int busy_cyc, done_cnt, done_rel, m_id, m_rel;
  logic err_at1;
  initial m_id = 0;
  always @(negedge clk) begin
    if (m_id != run_id) begin
      q_rd.delete(); q_beat.delete(); q_sb.delete(); q_wa.delete(); q_wd.delete();
      busy_cyc = 0; done_cnt = 0; done_rel = -1; err_at1 = 1'bx; m_id = run_id;
    end
    if (rst_n) begin
      m_rel = cyc - start_ref;
      if (m_rel == 1) err_at1 = bus.error;
      if (bus.acc_rd_en) q_rd.push_back(bus.acc_rd_addr);
      if (bus.ppu_valid) begin
        q_beat.push_back(bus.ppu_partial_sum);
        q_sb.push_back({bus.ppu_scale, bus.ppu_bias});
      end
      if (bus.out_wr_en) begin
        q_wa.push_back(bus.out_wr_addr);
        q_wd.push_back(bus.out_wr_data);
      end
      if (bus.busy) busy_cyc++;
      if (bus.run_done) begin
        if (done_cnt == 0) done_rel = m_rel;
        done_cnt++;
      end
    end
  end

  // ---------------- one run against the model ----------------
  // poke_rel: cycle (after start) to raise a stray start; -1 none, -2 the FIN cycle.
  task automatic run_case(input int n, input int base, input int sc, input int bi,
                          input int lat, input int hold, input bit spur, input int poke_rel);
    int lat_eff, exp_rel, budget, rel, poke, idx, a;
    logic exp_err;
    logic [PSUM_W-1:0] tmp;
    lat_eff = (lat == 0) ? TIMEOUT : lat;
    exp_rel = n * (ROWS + 1 + lat_eff + 1) + 1;
    exp_err = (lat == 0) && (n > 0);
    poke    = (poke_rel == -2) ? exp_rel : poke_rel;
    for (int t = 0; t < n; t++) begin
      tmp = rnd_wide();
      tile_data[t] = tmp[OUT_W-1:0];
    end
    @(negedge clk); #1;
    cfg_lat = lat; cfg_hold = hold; cfg_spur = spur;
    start_ref = cyc;
    run_id++;
    bus.start     = 1'b1;
    bus.num_tiles = TILE_W'(n);
    bus.base_addr = ADDR_W'(base);
    bus.cfg_scale = 8'(sc);
    bus.cfg_bias  = 8'(bi);
    budget = exp_rel + 60;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      rel = cyc - start_ref;
      bus.start     = (rel == poke);
      bus.num_tiles = TILE_W'($urandom_range(1, 63));
      bus.base_addr = ADDR_W'($urandom);
      bus.cfg_scale = 8'($urandom);
      bus.cfg_bias  = 8'($urandom);
      if (done_cnt > 0 && rel >= done_rel + 4) break;
    end
    bus.start = 1'b0;
    check("run_done_count", done_cnt, 1);
    check("run_done_cycle", done_rel, exp_rel);
    check("busy_cycles", busy_cyc, exp_rel - 1);
    check("error_after_start", err_at1, 1'b0);
    check("error_at_end", bus.error, exp_err);
    check("read_count", q_rd.size(), n * ROWS);
    check("beat_count", q_beat.size(), n * ROWS);
    check("write_count", q_wa.size(), n);
    for (int t = 0; t < n; t++) begin
      for (int r = 0; r < ROWS; r++) begin
        idx = t * ROWS + r;
        a   = (base + t * ROWS + r) % 256;
        if (idx < q_rd.size())   check("read_addr", q_rd[idx], a);
        if (idx < q_beat.size()) check("beat_data", q_beat[idx], mem[a]);
        if (idx < q_sb.size())   check("scale_bias", q_sb[idx], {sc[7:0], bi[7:0]});
      end
      if (t < q_wa.size()) begin
        check("write_addr", q_wa[t], t);
        check("write_data", q_wd[t], (lat == 0) ? '0 : tile_data[t]);
      end
    end
  endtask

  // Reset asserted mid-FETCH must drop every strobe without waiting for a clock.
  task automatic reset_mid_fetch();
    @(negedge clk); #1;
    cfg_lat = 3; cfg_hold = 1; cfg_spur = 0;
    start_ref = cyc;
    run_id++;
    bus.start = 1'b1; bus.num_tiles = TILE_W'(2); bus.base_addr = 8'h33;
    @(negedge clk); #1;
    bus.start = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    check("t1_pre_rd_en", bus.acc_rd_en, 1'b1);
    check("t1_pre_busy", bus.busy, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("t1_rd_en", bus.acc_rd_en, 1'b0);
    check("t1_ppu_valid", bus.ppu_valid, 1'b0);
    check("t1_busy", bus.busy, 1'b0);
    check("t1_wr_en", bus.out_wr_en, 1'b0);
    check("t1_run_done", bus.run_done, 1'b0);
    check("t1_writes", q_wa.size(), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0; bus.num_tiles = '0; bus.base_addr = '0;
    bus.cfg_scale = '0; bus.cfg_bias = '0;
    for (int i = 0; i < 256; i++) mem[i] = rnd_wide();
    #3;
    check("rst_acc_rd_en", bus.acc_rd_en, 1'b0);
    check("rst_acc_rd_addr", bus.acc_rd_addr, '0);
    check("rst_ppu_valid", bus.ppu_valid, 1'b0);
    check("rst_ppu_scale_bias", {bus.ppu_scale, bus.ppu_bias}, '0);
    check("rst_out_wr_en", bus.out_wr_en, 1'b0);
    check("rst_out_wr_data", bus.out_wr_data, '0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_run_done", bus.run_done, 1'b0);
    check("rst_error", bus.error, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // one tile, PPU answers 5 cycles after the last beat
    run_case(1, 8'h10, 3, 2, 5, 1, 1'b0, -1);
    // three tiles with read-address wrap
    run_case(3, 8'hF0, $urandom_range(0, 255), $urandom_range(0, 255), 3, 1, 1'b0, -1);
    // empty run, stray start while busy, stray start in the FIN cycle
    run_case(0, 8'h20, 7, 9, 2, 1, 1'b0, -1);
    run_case(2, 8'h40, 11, 12, 4, 1, 1'b0, 10);
    run_case(1, 8'h80, 5, 6, 2, 1, 1'b0, -2);
    // done pulsed during FETCH and held 4 cycles in WAIT; fastest PPU
    run_case(2, 8'hC8, 1, 1, 3, 4, 1'b1, -1);
    run_case(2, 8'h00, 9, 8, 1, 2, 1'b0, -1);
    // reset mid-run, then recover
    reset_mid_fetch();
    run_case(1, 8'h55, 4, 4, 2, 1, 1'b0, -1);
    // randomized runs
    for (int k = 0; k < 8; k++) begin
      int pk;
      pk = $urandom_range(0, 2);
      run_case($urandom_range(1, 4), $urandom_range(0, 255), $urandom_range(0, 255),
               $urandom_range(0, 255), $urandom_range(1, 8), $urandom_range(1, 4),
               1'($urandom_range(0, 1)), (pk == 0) ? -1 : ((pk == 1) ? 7 : -2));
    end
`ifdef PPU_TIMEOUT_EN
    // PPU never answers: zero writes and sticky error, cleared by next start
    run_case(2, 8'hFE, 3, 3, 0, 1, 1'b0, -1);
    run_case(1, 8'h12, 6, 7, 3, 1, 1'b0, -1);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
`default_nettype wire
